// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, rx state encoding and tick-width helper
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = IDLE,
        ST_START  = START,
        ST_DATA   = DATA,
        ST_PARITY = PARITY,
        ST_STOP   = STOP
    } rx_state_t;

    // Tick counter must cover both the per-bit count and the stop-phase count.
    function automatic int tick_width(input int ovs, input int sb);
        int m;
        m = (ovs > sb) ? ovs : sb;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// rtl/uart_rx_cfg_if.sv - receiver result bundle towards the RX FIFO
interface uart_rx_cfg_if #(
    parameter int DBIT = 8
);
    logic            rx_done_tick;
    logic [DBIT-1:0] rx_dout;
    logic            parity_err;
    logic            frame_err;
    logic            break_det;

    modport master (
        output rx_done_tick, rx_dout, parity_err, frame_err, break_det
    );

    modport slave (
        input rx_done_tick, rx_dout, parity_err, frame_err, break_det
    );
endinterface

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser with configurable reset value
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - runtime-configurable oversampling UART receiver
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int OVS     = 16,
    parameter int SB_TICK = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx,
    input  logic         s_tick,
    input  logic [1:0]   parity_mode,
    uart_rx_cfg_if.master rx_out
);
    localparam int SW = tick_width(OVS, SB_TICK);
    localparam int NW = $clog2(DBIT + 1);
    localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    logic w_rx_s;

    rx_state_t       r_state, w_state;
    logic [SW-1:0]   r_s, w_s;
    logic [NW-1:0]   r_n, w_n;
    logic [DBIT-1:0] r_shift, w_shift;
    logic            r_par, w_par;
    logic [1:0]      r_mode, w_mode;
    logic            r_pbit, w_pbit;
    logic            r_perr_pend, w_perr_pend;
    logic            r_ferr_pend, w_ferr_pend;
    logic            r_done, w_done;
    logic [DBIT-1:0] r_dout, w_dout;
    logic            r_perr, w_perr;
    logic            r_ferr, w_ferr;
    logic            r_brk, w_brk;
    logic            w_par_en;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    assign w_par_en = (r_mode == PAR_EVEN) || (r_mode == PAR_ODD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_s         <= '0;
            r_n         <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_mode      <= PAR_NONE;
            r_pbit      <= 1'b0;
            r_perr_pend <= 1'b0;
            r_ferr_pend <= 1'b0;
            r_done      <= 1'b0;
            r_dout      <= '0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_brk       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_s         <= w_s;
            r_n         <= w_n;
            r_shift     <= w_shift;
            r_par       <= w_par;
            r_mode      <= w_mode;
            r_pbit      <= w_pbit;
            r_perr_pend <= w_perr_pend;
            r_ferr_pend <= w_ferr_pend;
            r_done      <= w_done;
            r_dout      <= w_dout;
            r_perr      <= w_perr;
            r_ferr      <= w_ferr;
            r_brk       <= w_brk;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_s         = r_s;
        w_n         = r_n;
        w_shift     = r_shift;
        w_par       = r_par;
        w_mode      = r_mode;
        w_pbit      = r_pbit;
        w_perr_pend = r_perr_pend;
        w_ferr_pend = r_ferr_pend;
        w_done      = 1'b0;
        w_dout      = r_dout;
        w_perr      = r_perr;
        w_ferr      = r_ferr;
        w_brk       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!w_rx_s) begin
                    w_state     = ST_START;
                    w_s         = '0;
                    w_n         = '0;
                    w_shift     = '0;
                    w_par       = 1'b0;
                    w_mode      = parity_mode;
                    w_pbit      = 1'b0;
                    w_perr_pend = 1'b0;
                    w_ferr_pend = 1'b0;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (r_s == S_HALF) begin
                        w_s = '0;
                        if (w_rx_s) w_state = ST_IDLE;
                        else        w_state = ST_DATA;
                    end else begin
                        w_s = r_s + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (r_s == S_BIT) begin
                        w_s     = '0;
                        w_shift = {w_rx_s, r_shift[DBIT-1:1]};
                        w_par   = r_par ^ w_rx_s;
                        if (r_n == N_LAST) begin
                            if (w_par_en) w_state = ST_PARITY;
                            else          w_state = ST_STOP;
                        end else begin
                            w_n = r_n + 1'b1;
                        end
                    end else begin
                        w_s = r_s + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (s_tick) begin
                    if (r_s == S_BIT) begin
                        w_s         = '0;
                        w_pbit      = w_rx_s;
                        w_perr_pend = ((r_par ^ w_rx_s) != (r_mode == PAR_ODD));
                        w_state     = ST_STOP;
                    end else begin
                        w_s = r_s + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    w_s = r_s + 1'b1;
                    // Stop sample and completion may fall on the same tick when SB_TICK == OVS.
                    if (r_s == S_BIT) w_ferr_pend = r_ferr_pend | ~w_rx_s;
                    if (r_s == S_STOP) begin
                        w_done  = 1'b1;
                        w_dout  = r_shift;
                        w_perr  = r_perr_pend;
                        w_ferr  = w_ferr_pend;
                        w_brk   = (r_shift == '0) && (!w_par_en || !r_pbit) && w_ferr_pend;
                        w_s     = '0;
                        w_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_s     = '0;
            end
        endcase
    end

    assign rx_out.rx_done_tick = r_done;
    assign rx_out.rx_dout      = r_dout;
    assign rx_out.parity_err   = r_perr;
    assign rx_out.frame_err    = r_ferr;
    assign rx_out.break_det    = r_brk;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - randomized scoreboard bench for two receiver configurations
module tb_uart_rx_cfg;
    import uart_pkg::*;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       s_tick;
    logic       rx8, rx5;
    logic [1:0] pm8, pm5;

    int total;
    int bad;
    int n_done8;
    int n_done5;
    int tick_cnt;

    exp_t q8[$];
    exp_t q5[$];
    exp_t l8, l5;

    uart_rx_cfg_if #(.DBIT(8)) if8 ();
    uart_rx_cfg_if #(.DBIT(5)) if5 ();

    uart_rx_cfg #(.DBIT(8), .OVS(16), .SB_TICK(16)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx8),
        .s_tick      (s_tick),
        .parity_mode (pm8),
        .rx_out      (if8)
    );

    uart_rx_cfg #(.DBIT(5), .OVS(16), .SB_TICK(32)) dut5 (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx5),
        .s_tick      (s_tick),
        .parity_mode (pm5),
        .rx_out      (if5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        s_tick   = 1'b0;
        tick_cnt = 0;
        forever begin
            @(negedge clk);
            tick_cnt = (tick_cnt + 1) % 4;
            s_tick   = (tick_cnt == 0);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst8_done", 32'(if8.rx_done_tick), 0);
            chk("rst8_dout", 32'(if8.rx_dout), 0);
            chk("rst8_flags", {29'd0, if8.parity_err, if8.frame_err, if8.break_det}, 0);
            chk("rst5_done", 32'(if5.rx_done_tick), 0);
            chk("rst5_dout", 32'(if5.rx_dout), 0);
            chk("rst5_flags", {29'd0, if5.parity_err, if5.frame_err, if5.break_det}, 0);
            l8 = '{default: 0};
            l5 = '{default: 0};
            q8.delete();
            q5.delete();
        end else begin
            if (if8.rx_done_tick) begin
                n_done8++;
                if (q8.size() == 0) chk("done8_unexpected", 1, 0);
                else l8 = q8.pop_front();
                chk("done8_brk", 32'(if8.break_det), 32'(l8.brk));
            end else begin
                chk("idle8_brk", 32'(if8.break_det), 0);
            end
            chk("out8_dout", 32'(if8.rx_dout), 32'(l8.data));
            chk("out8_perr", 32'(if8.parity_err), 32'(l8.perr));
            chk("out8_ferr", 32'(if8.frame_err), 32'(l8.ferr));

            if (if5.rx_done_tick) begin
                n_done5++;
                if (q5.size() == 0) chk("done5_unexpected", 1, 0);
                else l5 = q5.pop_front();
                chk("done5_brk", 32'(if5.break_det), 32'(l5.brk));
            end else begin
                chk("idle5_brk", 32'(if5.break_det), 0);
            end
            chk("out5_dout", 32'(if5.rx_dout), 32'(l5.data));
            chk("out5_perr", 32'(if5.parity_err), 32'(l5.perr));
            chk("out5_ferr", 32'(if5.frame_err), 32'(l5.ferr));
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rx(input int w, input logic v);
        if (w == 8) rx8 = v;
        else        rx5 = v;
    endtask

    // Drives one frame bit by bit (64 clk per bit) and queues what the receiver must report.
    task automatic send(input int w, input logic [8:0] data, input logic [1:0] mode,
                        input logic pflip, input logic stopv, input int gap);
        int         db;
        int         sbt;
        int         ones;
        logic       par_en;
        logic       pbit;
        logic [8:0] mask;
        logic [8:0] d;
        exp_t       e;
        db     = (w == 8) ? 8 : 5;
        sbt    = (w == 8) ? 16 : 32;
        mask   = (9'h1 << db) - 9'h1;
        d      = data & mask;
        par_en = (mode == PAR_EVEN) || (mode == PAR_ODD);
        ones   = 0;
        for (int i = 0; i < db; i++) ones += int'(d[i]);
        pbit   = logic'(ones % 2) ^ (mode == PAR_ODD) ^ pflip;
        e.data = d;
        e.perr = par_en && ((((ones + int'(pbit)) % 2) == 1) != (mode == PAR_ODD));
        e.ferr = !stopv;
        e.brk  = (d == 0) && (!par_en || !pbit) && !stopv;
        if (w == 8) begin pm8 = mode; q8.push_back(e); end
        else        begin pm5 = mode; q5.push_back(e); end
        set_rx(w, 1'b0);
        wait_clk(64);
        for (int i = 0; i < db; i++) begin
            set_rx(w, d[i]);
            wait_clk(64);
        end
        if (par_en) begin
            set_rx(w, pbit);
            wait_clk(64);
        end
        if (stopv) begin
            set_rx(w, 1'b1);
            wait_clk(sbt * 4);
        end else begin
            set_rx(w, 1'b0);
            wait_clk(48);
            set_rx(w, 1'b1);
            wait_clk(sbt * 4 - 48);
        end
        set_rx(w, 1'b1);
        wait_clk(gap * 64);
    endtask

    initial begin
        int   d0;
        exp_t b;
        total   = 0;
        bad     = 0;
        n_done8 = 0;
        n_done5 = 0;
        rst_n   = 1'b0;
        rx8     = 1'b1;
        rx5     = 1'b1;
        pm8     = PAR_NONE;
        pm5     = PAR_NONE;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(20);

        send(8, 9'h0A5, PAR_NONE, 1'b0, 1'b1, 1);
        chk("a5_dout", 32'(if8.rx_dout), 32'h0A5);
        chk("a5_flags", {29'd0, if8.parity_err, if8.frame_err, if8.break_det}, 0);
        send(8, 9'h037, PAR_EVEN, 1'b0, 1'b1, 1);
        chk("even_ok_perr", 32'(if8.parity_err), 0);
        send(8, 9'h037, PAR_EVEN, 1'b1, 1'b1, 1);
        chk("even_bad_perr", 32'(if8.parity_err), 1);
        chk("even_bad_dout", 32'(if8.rx_dout), 32'h037);
        send(8, 9'h000, PAR_ODD, 1'b0, 1'b1, 1);
        chk("odd_ok_perr", 32'(if8.parity_err), 0);
        send(8, 9'h000, PAR_ODD, 1'b0, 1'b0, 1);
        chk("odd_ferr", 32'(if8.frame_err), 1);
        chk("odd_ferr_dout", 32'(if8.rx_dout), 0);

        // Glitch shorter than half a bit: rejected at the mid-start resample.
        d0 = n_done8;
        rx8 = 1'b0;
        wait_clk(20);
        rx8 = 1'b1;
        wait_clk(120);
        chk("glitch_no_done", 32'(n_done8 - d0), 0);
        send(8, 9'h05A, PAR_NONE, 1'b0, 1'b1, 1);
        chk("after_glitch_dout", 32'(if8.rx_dout), 32'h05A);

        // A frame occupies 9.5 bit times here, so 1840 clk of low line yields three frames.
        pm8 = PAR_NONE;
        b   = '{data: 9'h0, perr: 1'b0, ferr: 1'b1, brk: 1'b1};
        for (int i = 0; i < 3; i++) q8.push_back(b);
        d0 = n_done8;
        rx8 = 1'b0;
        wait_clk(1840);
        rx8 = 1'b1;
        wait_clk(200);
        chk("break_frames", 32'(n_done8 - d0), 3);
        chk("break_ferr", 32'(if8.frame_err), 1);

        for (int i = 0; i < 24; i++) begin
            logic stopv;
            stopv = ($urandom % 5) != 0;
            send(8, 9'($urandom % 256), 2'($urandom % 4), ($urandom % 4) == 0, stopv,
                 stopv ? int'($urandom % 2) : 1);
        end

        send(5, 9'h01F, PAR_NONE, 1'b0, 1'b1, 0);
        send(5, 9'h00A, PAR_NONE, 1'b0, 1'b1, 2);
        chk("b2b_dout5", 32'(if5.rx_dout), 32'h0A);
        chk("b2b_count5", 32'(n_done5), 2);
        for (int i = 0; i < 6; i++) begin
            send(5, 9'($urandom % 32), 2'($urandom % 4), ($urandom % 3) == 0, 1'b1,
                 int'($urandom % 2));
        end

        send(8, 9'h0C3, PAR_NONE, 1'b0, 1'b1, 1);
        chk("pre_rst_dout", 32'(if8.rx_dout), 32'h0C3);
        chk("queues_drained", 32'(q8.size() + q5.size()), 0);

        rx8 = 1'b0;
        wait_clk(64 * 4);
        rx8 = 1'b1;
        wait_clk(16);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_dout", 32'(if8.rx_dout), 0);
        chk("async_rst_done", 32'(if8.rx_done_tick), 0);
        wait_clk(4);
        rst_n = 1'b1;
        d0 = n_done8;
        wait_clk(1200);
        chk("post_rst_no_done", 32'(n_done8 - d0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
